// File: rtl/monty_pkg.sv
// Shared types and helpers for the Montgomery multiply/reduce datapath.
package monty_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    function automatic int ndig(input int logq, input int w);
        return logq / w;
    endfunction

endpackage

// File: rtl/mul_digit.sv
// Combinational LOGQ x W unsigned multiplier; isolated so it can be swapped for a DSP-mapped version.
module mul_digit #(
    parameter int LOGQ = 64,
    parameter int W    = 16
) (
    input  logic [LOGQ-1:0]   a_i,
    input  logic [W-1:0]      d_i,
    output logic [LOGQ+W-1:0] p_o
);

    assign p_o = (LOGQ+W)'(a_i) * (LOGQ+W)'(d_i);

endmodule

// File: rtl/mul_serial.sv
// Word-serial multiplier: C = A*B, B consumed W bits per cycle MSB-first, qH sideband kept aligned.
module mul_serial
    import monty_pkg::*;
#(
    parameter int LOGQ  = 64,
    parameter int LOGQH = 32,
    parameter int W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LOGQ-1:0]   A,
    input  logic [LOGQ-1:0]   B,
    input  logic [LOGQH-1:0]  qH_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*LOGQ-1:0] C,
    output logic [LOGQH-1:0]  qH_out
);

    localparam int NDIG = ndig(LOGQ, W);
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int AW   = 2 * LOGQ;

    if ((LOGQ % W) != 0) begin : g_bad_digit_width
        $error("mul_serial: LOGQ must be a multiple of W");
    end

    mul_state_t        state_q;
    logic [LOGQ-1:0]   a_q;
    logic [LOGQ-1:0]   b_q;
    logic [LOGQH-1:0]  qh_q;
    logic [AW-1:0]     acc_q;
    logic [AW-1:0]     acc_d;
    logic [CW-1:0]     cnt_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [LOGQ+W-1:0] pp;

    // b_q shifts left each digit, so its top W bits are always B[LOGQ-1-W*cnt -: W].
    mul_digit #(
        .LOGQ (LOGQ),
        .W    (W)
    ) u_digit (
        .a_i (a_q),
        .d_i (b_q[LOGQ-1 -: W]),
        .p_o (pp)
    );

    always_comb begin
        acc_d = (acc_q << W) + AW'(pp);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            qh_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= A;
                        b_q        <= B;
                        qh_q       <= qH_in;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    b_q   <= b_q << W;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(NDIG - 1)) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign C         = acc_q;
    assign qH_out    = qh_q;

endmodule

// File: doc/mul_serial.md
# mul_serial

Word-serial integer multiplier that forms the 2·LOGQ-bit product C = A·B consumed by the word-level Montgomery reduction stage (`wlm` / `wlm_mixed`) directly downstream. Operand B is processed W bits per cycle, most significant digit first, trading throughput for a small LOGQ×W multiplier. A qH sideband travels with each operand pair so that C and its modulus half reach the reduction stage aligned. Valid/ready handshakes sit on both sides.

## Interface
- LOGQ, 64, operand width in bits.
- LOGQH, 32, width of the qH sideband; matches the reduction stage.
- W, 16, digit width of B per cycle; LOGQ % W == 0 is required, elaboration fails otherwise.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  A, B and qH_in are valid.
- in_ready  out  1  block can accept an operand pair.
- A  in  LOGQ  multiplicand.
- B  in  LOGQ  multiplier, split into NDIG = LOGQ/W digits.
- qH_in  in  LOGQH  sideband, captured with A and B.
- out_valid  out  1  C and qH_out hold a finished product.
- out_ready  in  1  consumer accepts C.
- C  out  2·LOGQ  product A·B.
- qH_out  out  LOGQH  qH captured with the operands.

## Operation
- FSM states: IDLE, RUN, DONE. in_ready = (state == IDLE); out_valid = (state == DONE).
- IDLE: on in_valid && in_ready, register A, B and qH_in, clear acc and cnt, and move to RUN.
- RUN: each cycle, acc ← (acc << W) + A · B[LOGQ-1-W·cnt -: W], then cnt ← cnt+1. After the digit with cnt = NDIG-1, move to DONE.
- DONE: C = acc and qH_out = the registered qH are held stable. On out_ready, move to IDLE.
- in_ready is low in RUN and DONE. Inputs presented then are ignored and do not need to be held.
- The output holds under backpressure indefinitely. C, qH_out and out_valid must not change while out_valid && !out_ready.
- Width rules:
  - Partial product is LOGQ+W bits.
  - acc is 2·LOGQ bits.
  - The MSB-first shift-add never overflows, because after k digits acc < 2^(LOGQ+W·k).
  - All arithmetic is unsigned. There are no truncation points other than the explicit digit slice.
- cnt width is $clog2(NDIG), minimum 1. It does not wrap inside RUN because the exit occurs at NDIG-1.
- in_valid with out_ready in the same cycle cannot occur as a transfer, since IDLE and DONE are disjoint states. in_valid during DONE is ignored.

## Timing
- Reset, asserted at any time including mid-RUN or mid-DONE:
  - state = IDLE, acc = 0, cnt = 0, C = 0, qH_out = 0, out_valid = 0.
  - in_ready = 1, since it decodes from IDLE. Upstream must not drive in_valid while rst_n is low; handshakes are ignored during reset.
  - An operation in flight is discarded, and no partial C is ever presented.
- Latency: if the input is accepted at edge k, digits are processed at edges k+1 … k+NDIG. out_valid is high after edge k+NDIG, which is 4 cycles for the defaults.
- Throughput: one product every NDIG+2 cycles with out_ready held high. That is 1 accept cycle, NDIG run cycles and ≥1 DONE cycle.
- After out_ready is sampled high in DONE, in_ready is high in the next cycle.
- The digit multiply and add are combinational within one cycle. No internal pipelining is introduced.

## Structure
- Shared package `monty_pkg` holds:
  - the state enum `mul_state_t` (IDLE, RUN, DONE);
  - the function `ndig(LOGQ, W)` returning LOGQ/W.
- One sub-module, `mul_digit`: combinational LOGQ×W unsigned multiplier returning LOGQ+W bits. It is instantiated once, so it can later be swapped for a DSP-mapped version.
- The FSM, accumulator and sideband registers live in `mul_serial`.

## Test plan
All scenarios use defaults LOGQ=64, W=16, LOGQH=32, with a bench reading hex vectors the same way the `wlm` bench does.
- A=3, B=5, qH_in=0xDEADBEEF, out_ready=1 -> out_valid rises 4 cycles after accept; C=0xF; qH_out=0xDEADBEEF; in_ready returns the cycle after the transfer.
- A=B=0xFFFFFFFFFFFFFFFF -> C=0xFFFFFFFFFFFFFFFE0000000000000001; no overflow.
- A=0x0123456789ABCDEF, B=0x1 (only the least significant digit non-zero), and A=0x1, B=0x8000000000000000 -> C=0x0123456789ABCDEF and C=0x8000000000000000, checking digit order.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> C, qH_out and out_valid stay constant; in_ready=0; a changing in_valid/A/B during this window is ignored; out_ready=1 completes the transfer.
- Reset mid-RUN: assert rst_n=0 at cnt=2 -> out_valid=0, C=0, state IDLE immediately; after release, a new pair A=7, B=9 yields C=0x3F.
- Stream of 1000 random pairs with random out_ready -> every C matches the golden A·B and qH_out matches in order, with no drops or duplicates.
